// File: rtl/cnt_seq_pkg.sv
// Package: cnt_seq_pkg
// Shared types and helpers for count_sequencer and its arbiter.
//   state_t        : sequencer FSM state encoding (2-bit)
//   CNT_SEQ_WIDTH  : default counter / len width
//   MAX_NREQ       : largest supported requester count
//   IDX_W          : width of a requester index (covers MAX_NREQ)
//   onehot()       : index -> one-hot vector of MAX_NREQ bits
package cnt_seq_pkg;

    localparam int CNT_SEQ_WIDTH = 4;
    localparam int MAX_NREQ      = 8;
    localparam int IDX_W         = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/cnt_seq_arb.sv
// Module: cnt_seq_arb
// Combinational requester picker for count_sequencer.
// Build option CNT_SEQ_RR_EN: when defined, the search starts at ptr and
// wraps (round-robin); otherwise the lowest requesting index wins and there
// is no ptr port.
// Ports:
//   req     in   NREQ    request vector
//   ptr     in   IDX_W   round-robin start index (CNT_SEQ_RR_EN only)
//   any     out  1       at least one request present
//   winner  out  NREQ    one-hot winner, zero when no request
//   idx     out  IDX_W   winner index, zero when no request
module cnt_seq_arb
    import cnt_seq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
`ifdef CNT_SEQ_RR_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic             any,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] idx
);

    int rank;
    int best;

    // Each requester gets a rank (its distance from the search start); the
    // smallest rank among active requesters wins.
    always_comb begin
        idx  = '0;
        best = NREQ;
        rank = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef CNT_SEQ_RR_EN
            rank = k - int'(ptr);
            if (rank < 0) rank = rank + NREQ;
`else
            rank = k;
`endif
            if (req[k] && (rank < best)) begin
                best = rank;
                idx  = IDX_W'(k);
            end
        end
    end

    assign any    = |req;
    assign winner = any ? NREQ'(onehot(idx)) : '0;

endmodule

// File: rtl/count_sequencer.sv
// Module: count_sequencer
// Shares one external counter among NREQ requesters. A granted requester's
// len is latched as the target, the counter is cleared for one cycle, then
// counting is enabled until the counter equals the target, after which the
// requester gets a one-cycle done pulse and the grant is released.
// Build option CNT_SEQ_RR_EN: round-robin arbitration (see cnt_seq_arb);
// default is fixed priority, lowest index first.
// Ports:
//   clk          in   1           clock, posedge
//   reset        in   1           synchronous reset, active-low
//   req          in   NREQ        level requests
//   len          in   NREQ*WIDTH  per-requester target, slice i = [i*WIDTH +: WIDTH]
//   gnt          out  NREQ        one-hot grant, registered
//   done         out  NREQ        one-cycle completion pulse, registered
//   busy         out  1           not IDLE
//   cnt_reset_n  out  1           counter synchronous reset, active-low
//   cnt_count    out  1           counter count enable
//   cnt_value    in   WIDTH       counter value
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// CLEAR | counter held in reset for one cycle
// RUN   | counter enabled until it equals the latched target
// DONE  | done pulse to the granted requester; grant drops on exit
module count_sequencer
    import cnt_seq_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = CNT_SEQ_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  cnt_reset_n,
    output logic                  cnt_count,
    input  logic [WIDTH-1:0]      cnt_value
);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   target;
    logic [WIDTH-1:0]   len_sel;
    logic               at_target;
    logic               any;
    logic [NREQ-1:0]    winner;
    logic [IDX_W-1:0]   win_idx;

`ifdef CNT_SEQ_RR_EN
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
`endif

    cnt_seq_arb #(.NREQ(NREQ)) u_arb (
        .req    (req),
`ifdef CNT_SEQ_RR_EN
        .ptr    (ptr),
`endif
        .any    (any),
        .winner (winner),
        .idx    (win_idx)
    );

    always_comb begin
        len_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IDX_W'(k)) len_sel = len[k*WIDTH +: WIDTH];
        end
    end

    assign at_target = (cnt_value == target);

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        busy        = (state != IDLE);
        cnt_count   = 1'b0;
        // Counter also clears while the sequencer is in reset.
        cnt_reset_n = reset & (state != CLEAR);
        case (state)
            IDLE:  if (any) state_nxt = CLEAR;
            CLEAR: state_nxt = RUN;
            RUN: begin
                cnt_count = ~at_target;
                if (at_target) state_nxt = DONE;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt    <= '0;
            done   <= '0;
            target <= '0;
`ifdef CNT_SEQ_RR_EN
            ptr     <= '0;
            gnt_idx <= '0;
`endif
        end else begin
            done <= (state == RUN && at_target) ? gnt : '0;
            if (state == IDLE && any) begin
                gnt    <= winner;
                target <= len_sel;
`ifdef CNT_SEQ_RR_EN
                gnt_idx <= win_idx;
`endif
            end
            if (state == DONE) begin
                gnt <= '0;
`ifdef CNT_SEQ_RR_EN
                ptr <= (gnt_idx == IDX_W'(NREQ-1)) ? '0 : gnt_idx + IDX_W'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  cnt_reset_n;
    logic                  cnt_count;
    logic [WIDTH-1:0]      cnt_value = '0;

    count_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .len         (len),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .cnt_reset_n (cnt_reset_n),
        .cnt_count   (cnt_count),
        .cnt_value   (cnt_value)
    );

    always #5 clk = ~clk;

    // Shared 4-bit counter driven by the sequencer's pins.
    always_ff @(posedge clk) begin
        if (!cnt_reset_n)   cnt_value <= '0;
        else if (cnt_count) cnt_value <= cnt_value + 1'b1;
    end

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] vec;
        int              len;
        bit              aborted;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   active    = 1'b0;
    bit   b2b_chk   = 1'b0;
    int   g_cyc     = 0;
    int   cnt_hi    = 0;
    int   jobs_done = 0;
    int   last_fall = -1;
    logic [NREQ-1:0] prev_gnt  = '0;
    logic [NREQ-1:0] prev_done = '0;

    // Monitor: pops the expected job at grant and checks it at done / release.
    always @(negedge clk) begin
        if (gnt != '0 && prev_gnt == '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", 32'(gnt), 32'd0);
            end else begin
                cur = sb.pop_front();
                chk("grant_vec", 32'(gnt), 32'(cur.vec));
                if (b2b_chk && last_fall >= 0) chk("idle_gap", cyc - last_fall, 32'd1);
                active = 1'b1;
                g_cyc  = cyc;
                cnt_hi = 0;
            end
        end
        if (active && cnt_count) cnt_hi++;
        if (done != '0) begin
            if (!active || cur.aborted) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                chk("done_vec", 32'(done), 32'(cur.vec));
                chk("done_latency", cyc - g_cyc, cur.len + 2);
                chk("count_cycles", cnt_hi, cur.len);
                chk("cnt_at_target", 32'(cnt_value), cur.len);
                jobs_done++;
            end
        end
        if (prev_done != '0) chk("done_width", 32'(done), 32'd0);
        if (gnt == '0 && prev_gnt != '0) begin
            if (active && !cur.aborted) chk("gnt_fall", cyc - g_cyc, cur.len + 3);
            active    = 1'b0;
            last_fall = b2b_chk ? cyc : -1;
        end
        prev_gnt  = gnt;
        prev_done = done;
    end

    task automatic wait_gnt(input string tag, input int budget);
        int n = 0;
        while (gnt == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(gnt != '0), 32'd1);
    endtask

    task automatic wait_jobs(input string tag, input int target_jobs, input int budget);
        int n = 0;
        while (jobs_done < target_jobs && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(jobs_done >= target_jobs), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},    32'(gnt),         32'd0);
        chk({tag, "_done"},   32'(done),        32'd0);
        chk({tag, "_busy"},   32'(busy),        32'd0);
        chk({tag, "_crst"},   32'(cnt_reset_n), 32'd0);
        chk({tag, "_ccount"}, 32'(cnt_count),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset held with all requests active
        reset = 1'b0;
        req   = 4'b1111;
        len   = 16'h2222;
        repeat (3) begin
            @(negedge clk);
            chk_reset_outputs("t1");
        end
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 2: single job, len 5
        len[3:0] = 4'd5;
        req      = 4'b0001;
        sb.push_back('{vec: 4'b0001, len: 5, aborted: 1'b0});
        wait_gnt("t2_grant", 5);
        chk("t2_busy", 32'(busy), 32'd1);
        req = '0;
        wait_jobs("t2_done", 1, 30);
        repeat (3) @(negedge clk);
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_idle_gnt",  32'(gnt),  32'd0);

        // 3: len 0
        len[3:0] = 4'd0;
        req      = 4'b0001;
        sb.push_back('{vec: 4'b0001, len: 0, aborted: 1'b0});
        wait_gnt("t3_grant", 5);
        req = '0;
        wait_jobs("t3_done", 2, 20);
        repeat (3) @(negedge clk);

        // 5: reset pulsed mid-job
        len[7:4] = 4'd15;
        req      = 4'b0010;
        sb.push_back('{vec: 4'b0010, len: 15, aborted: 1'b1});
        wait_gnt("t5_grant", 5);
        req = '0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t5");
        chk("t5_counter", 32'(cnt_value), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_done", jobs_done, 32'd2);
        chk("t5_gnt_idle", 32'(gnt), 32'd0);

        // 4: all requesting, back-to-back jobs
        b2b_chk = 1'b1;
        len     = 16'h2222;
        req     = 4'b1111;
`ifdef CNT_SEQ_RR_EN
        sb.push_back('{vec: 4'b0001, len: 2, aborted: 1'b0});
        sb.push_back('{vec: 4'b0010, len: 2, aborted: 1'b0});
        sb.push_back('{vec: 4'b0100, len: 2, aborted: 1'b0});
        sb.push_back('{vec: 4'b1000, len: 2, aborted: 1'b0});
        sb.push_back('{vec: 4'b0001, len: 2, aborted: 1'b0});
`else
        repeat (5) sb.push_back('{vec: 4'b0001, len: 2, aborted: 1'b0});
`endif
        wait_jobs("t4_done", 7, 100);
        req = '0;
        repeat (4) @(negedge clk);
        b2b_chk = 1'b0;
        chk("t4_gnt_idle", 32'(gnt), 32'd0);
        chk("t4_sb_empty", sb.size(), 32'd0);

        // 6: req dropped and len changed mid-job
        len[3:0] = 4'd4;
        req      = 4'b0001;
        sb.push_back('{vec: 4'b0001, len: 4, aborted: 1'b0});
        wait_gnt("t6_grant", 5);
        @(negedge clk);
        req      = '0;
        len[3:0] = 4'd9;
        wait_jobs("t6_done", 8, 30);
        repeat (3) @(negedge clk);
        chk("t6_gnt_idle", 32'(gnt), 32'd0);
        chk("t6_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
